// File: rtl/if_fetch.sv
// ============================================================================
// Module   : if_fetch
// Summary  : Instruction-fetch stage with credit-limited in-order fetch queue,
//            stall hold and branch redirect with stale-response dropping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int                   c_PTR_W   = $clog2(DEPTH);
  localparam int                   c_CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0]   c_ONE     = 1;
  localparam logic [c_PTR_W-1:0]   c_PTR_ONE = 1;
  localparam logic [c_CNT_W:0]     c_LIMIT   = (c_CNT_W + 1)'(DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [c_CNT_W-1:0] r_outst;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] r_drop;

  logic [31:0]        r_pend [DEPTH];
  logic [c_PTR_W-1:0] r_pend_wr;
  logic [c_PTR_W-1:0] r_pend_rd;

  logic [31:0]        r_qpc   [DEPTH];
  logic [31:0]        r_qinst [DEPTH];
  logic [c_PTR_W-1:0] r_q_wr;
  logic [c_PTR_W-1:0] r_q_rd;

  logic [c_CNT_W:0]   w_inflight;
  logic               w_fire;
  logic               w_rsp_drop;
  logic               w_rsp_keep;
  logic               w_pop;
  logic [c_CNT_W-1:0] w_outst_nxt;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic               w_unused_bits;

  assign w_unused_bits = ^branch_target_i[1:0];

  assign w_inflight = {1'b0, r_outst} + {1'b0, r_count};

  // Gating with rst keeps the request low for the whole reset, not just after the first edge.
  assign imem_req  = rst & (w_inflight < c_LIMIT) & (r_drop == '0) & ~branch_flag_i;
  assign imem_addr = r_fetch_pc;

  assign w_fire     = imem_req & imem_gnt;
  assign w_rsp_drop = imem_rvalid & (branch_flag_i | (r_drop != '0));
  assign w_rsp_keep = imem_rvalid & ~w_rsp_drop;
  assign w_pop      = if_valid & ~stall_i & ~branch_flag_i;

  assign w_outst_nxt = r_outst + (w_fire ? c_ONE : '0) - (imem_rvalid ? c_ONE : '0);
  assign w_count_nxt = r_count + (w_rsp_keep ? c_ONE : '0) - (w_pop ? c_ONE : '0);

  assign if_valid = (r_count != '0);
  assign if_pc    = if_valid ? r_qpc[r_q_rd]   : 32'h0;
  assign if_inst  = if_valid ? r_qinst[r_q_rd] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_count    <= '0;
      r_drop     <= '0;
      r_pend_wr  <= '0;
      r_pend_rd  <= '0;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
    end else if (branch_flag_i) begin
      // No request can fire here, so every remaining in-flight response is stale.
      r_fetch_pc <= {branch_target_i[31:2], 2'b00};
      r_outst    <= w_outst_nxt;
      r_drop     <= w_outst_nxt;
      r_count    <= '0;
      r_pend_wr  <= '0;
      r_pend_rd  <= '0;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      r_count <= w_count_nxt;
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_pend_wr  <= r_pend_wr + c_PTR_ONE;
      end
      if (w_rsp_drop) begin
        r_drop <= r_drop - c_ONE;
      end
      if (w_rsp_keep) begin
        r_pend_rd <= r_pend_rd + c_PTR_ONE;
        r_q_wr    <= r_q_wr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_q_rd <= r_q_rd + c_PTR_ONE;
      end
    end
  end

  // Storage needs no reset: every read is qualified by the occupancy counters.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_pend[r_pend_wr] <= r_fetch_pc;
    end
    if (w_rsp_keep) begin
      r_qpc[r_q_wr]   <= r_pend[r_pend_rd];
      r_qinst[r_q_wr] <= imem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module   : tb_if_fetch
// Summary  : Scoreboard bench for if_fetch with an in-order latency memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] c_XOR    = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          bufcnt = 0;
  int          stale = 0;
  int          pops = 0;
  logic [31:0] fetch_pc_m = RESET_PC;
  logic [31:0] fl_addr[$];
  int          fl_due[$];
  logic [31:0] sb_pc[$];
  logic [31:0] sb_inst[$];
  bit          hold = 1'b0;
  logic [31:0] hold_pc = 32'h0;
  logic [31:0] hold_inst = 32'h0;
  bit          done;
  bit          rnd_br;
  bit          rnd_st;
  logic [31:0] rnd_tgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    fl_addr.delete();
    fl_due.delete();
    sb_pc.delete();
    sb_inst.delete();
    bufcnt     = 0;
    stale      = 0;
    hold       = 1'b0;
    last_due   = 0;
    fetch_pc_m = RESET_PC;
  endtask

  // One clock cycle: drive at negedge, check, predict the posedge effects.
  task automatic step(input bit st, input bit br, input logic [31:0] tgt,
                      input int gpct, input int lmin, input int lmax);
    bit fire;
    bit rsp;
    bit pop;
    int due;
    @(negedge clk);
    stall_i         = st;
    branch_flag_i   = br;
    branch_target_i = tgt;
    imem_gnt        = ($urandom_range(99) < gpct);
    rsp             = (fl_due.size() != 0) && (fl_due[0] <= cyc);
    imem_rvalid     = rsp;
    imem_rdata      = rsp ? (fl_addr[0] ^ c_XOR) : 32'hDEAD_BEEF;
    #1;
    chk("if_valid", if_valid, bufcnt != 0);
    if (!if_valid) begin
      chk("idle_pc", if_pc, 32'h0);
      chk("idle_inst", if_inst, 32'h0);
    end
    if (hold) begin
      chk("hold_pc", if_pc, hold_pc);
      chk("hold_inst", if_inst, hold_inst);
    end
    if (br || stale != 0 || (fl_addr.size() + bufcnt) >= DEPTH)
      chk("imem_req_off", imem_req, 1'b0);
    else
      chk("imem_req_on", imem_req, 1'b1);

    fire = imem_req && imem_gnt;
    pop  = if_valid && !st && !br;
    hold = if_valid && st && !br;
    hold_pc   = if_pc;
    hold_inst = if_inst;

    if (pop) begin
      if (sb_pc.size() == 0) begin
        chk("unexpected_pop", if_valid, 1'b0);
      end else begin
        chk("if_pc", if_pc, sb_pc.pop_front());
        chk("if_inst", if_inst, sb_inst.pop_front());
      end
      pops++;
      if (bufcnt > 0) bufcnt--;
    end
    if (rsp) begin
      fl_addr.delete(0);
      fl_due.delete(0);
      if (stale > 0) stale--;
      else if (!br) bufcnt++;
    end
    if (fire) begin
      chk("imem_addr", imem_addr, fetch_pc_m);
      due = cyc + $urandom_range(lmax, lmin);
      if (due < last_due) due = last_due;
      last_due = due;
      fl_addr.push_back(imem_addr);
      fl_due.push_back(due);
      sb_pc.push_back(fetch_pc_m);
      sb_inst.push_back(fetch_pc_m ^ c_XOR);
      fetch_pc_m = fetch_pc_m + 32'd4;
    end
    if (br) begin
      sb_pc.delete();
      sb_inst.delete();
      bufcnt     = 0;
      stale      = fl_addr.size();
      fetch_pc_m = {tgt[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_req", imem_req, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Streaming with immediate grant and single-cycle latency
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 32'h0, 100, 1, 1);

    // Five-cycle stall, then drain
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 100, 1, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 100, 1, 1);

    // Branch to 0x103 while two requests are outstanding
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (fl_addr.size() == 2 && stale == 0) begin
        step(1'b0, 1'b1, 32'h0000_0103, 100, 3, 3);
        done = 1'b1;
      end else begin
        step(1'b0, 1'b0, 32'h0, 100, 3, 3);
      end
    end
    chk("br2_reached", done, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, 100, 1, 1);

    // Branch together with stall and an arriving response
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (fl_due.size() != 0 && fl_due[0] <= cyc && stale == 0 && bufcnt != 0) begin
        step(1'b1, 1'b1, 32'h0000_0200, 100, 2, 2);
        #1;
        chk("br_stall_flush", if_valid, 1'b0);
        done = 1'b1;
      end else begin
        step(1'b1, 1'b0, 32'h0, 100, 2, 2);
      end
    end
    chk("br_stall_reached", done, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, 100, 1, 1);

    // Random grants, latencies, stalls and branches
    pops = 0;
    for (int i = 0; i < 30000 && pops < 1000; i++) begin
      rnd_br  = ($urandom_range(99) < 3);
      rnd_st  = ($urandom_range(99) < 20);
      rnd_tgt = $urandom;
      step(rnd_st, rnd_br, rnd_tgt, 50, 1, 4);
    end
    chk("random_done", pops >= 1000, 1'b1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 100, 1, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", if_valid, 1'b0);
    chk("arst_pc", if_pc, 32'h0);
    chk("arst_inst", if_inst, 32'h0);
    chk("arst_req", imem_req, 1'b0);
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    stall_i       = 1'b0;
    branch_flag_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 100, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
